// File: rtl/tmac_acc_bi.sv
// tmac_acc_bi: popcount-accumulate LANES bipolar product streams over 2^WIN_LOG2 cycles, emit signed sum on valid/ready.
// Define MAC_SCALED_OUT_EN to emit the lane-mean (sum >>> log2(LANES)) instead of the raw sum.
module tmac_acc_bi #(
  parameter int LANES    = 16,
  parameter int WIN_LOG2 = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [LANES-1:0]                      iC,
  output logic                                  busy,
  output logic [WIN_LOG2+$clog2(LANES)+1:0]     oSum,
  output logic                                  oValid,
  input  logic                                  iReady
);
  localparam int CW = $clog2(LANES);
  localparam int PW = CW + 1;
  localparam int AW = WIN_LOG2 + CW + 1;
  localparam int OW = AW + 1;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t                r_state, w_next;
  logic [AW-1:0]         r_acc, w_fin;
  logic [WIN_LOG2-1:0]   r_cnt;
  logic [OW-1:0]         r_sum;
  logic [PW-1:0]         w_pop;
  logic signed [OW-1:0]  w_sum, w_out;
  logic                  w_last, w_go;
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) w_pop = w_pop + PW'(iC[i]);
  end
  assign w_last = r_cnt == '1;
  assign w_go   = start && (r_state == IDLE || (r_state == HOLD && iReady));
  assign w_fin  = r_acc + AW'(w_pop);
  // 2*ones - total bits; modular OW-bit arithmetic keeps +full-scale exact
  assign w_sum  = $signed(OW'({w_fin, 1'b0})) - $signed(OW'(LANES << WIN_LOG2));
`ifdef MAC_SCALED_OUT_EN
  assign w_out  = w_sum >>> CW;
`else
  assign w_out  = w_sum;
`endif
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? HOLD : RUN) :
             (r_state == HOLD) ? (iReady ? (start ? RUN : IDLE) : HOLD) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_acc <= w_fin;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == RUN && w_last) r_sum <= w_out;
    end
  end
  assign busy   = r_state == RUN;
  assign oValid = r_state == HOLD;
  assign oSum   = r_sum;
endmodule

// File: doc/tmac_acc_bi.md
Name: tmac_acc_bi

Overview:
Downstream accumulation stage of the bipolar temporal MAC16 array. Consumes the LANES single-bit product streams (oC) from the bipolar temporal multipliers over a fixed window of 2^WIN_LOG2 cycles. Popcounts and accumulates those streams, then converts the ones-count to a signed bipolar binary sum. Presents the result on a valid/ready handshake to the next binary stage.

Parameters:
LANES, 16, number of multiplier product streams accumulated (power of two, >=2)
WIN_LOG2, 8, log2 of window length in cycles; matches the multiplier operand width
OW, WIN_LOG2+$clog2(LANES)+2, signed output width (14 at defaults); derived, not overridden

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; issued in the same cycle the multipliers see loadA/loadB
iC  input  LANES  product bitstreams, one per multiplier lane
busy  output  1  high while accumulating (RUN)
oSum  output  OW  signed bipolar sum, two's complement
oValid  output  1  result available
iReady  input  1  consumer accepts oSum when oValid && iReady

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc=0; cnt=0; oSum=0; oValid=0; busy=0. Reset mid-RUN or mid-HOLD discards the partial or held result with no output.
- State IDLE: busy=0, oValid=0.
  - start=1 -> RUN next cycle, with acc=0 and cnt=0.
- State RUN: busy=1.
  - Each cycle: acc += popcount(iC) and cnt += 1.
  - acc width is WIN_LOG2+$clog2(LANES)+1 (max LANES*2^WIN_LOG2 = 4096 at defaults; no overflow).
  - When cnt reaches 2^WIN_LOG2-1 (last sample this cycle) -> HOLD next cycle.
  - First sample is taken in the cycle after start, aligned with multiplier stop deasserting one cycle after loadA.
  - Exactly 2^WIN_LOG2 samples are taken; cnt wraps to 0 on exit.
  - start during RUN is ignored.
- State HOLD: oValid=1, busy=0.
  - oSum = 2*acc - LANES*2^WIN_LOG2, registered on entry and stable until accepted.
  - Range -4096..+4096 at defaults.
- Latency: start at cycle t; samples at t+1..t+2^WIN_LOG2; oValid first high at t+2^WIN_LOG2+1 (t+257 at defaults).
- Handshake and start interaction:
  - oValid && iReady -> IDLE next cycle, oValid drops.
  - oValid && iReady && start in the same cycle -> handshake completes and the module goes directly to RUN (acc and cnt cleared), with no idle bubble.
  - start in HOLD without iReady is ignored. The upstream controller must not issue loadA until the result is accepted.
- oSum retains its last value in IDLE and RUN; it is only meaningful while oValid=1.
- X on iC outside RUN has no effect.

Optional Feature:
MAC_SCALED_OUT_EN
- Defined: oSum in HOLD = (2*acc - LANES*2^WIN_LOG2) >>> $clog2(LANES), an arithmetic shift with round toward negative infinity. The result is the scaled mean over lanes (range -256..+256 at defaults). Port width is still OW, sign-extended.
- Undefined: unscaled sum as above.
- Latency and handshake are identical in both builds.

Test Plan:
- All lanes iC=1 for the whole window, iReady=1 -> oValid at t+257, oSum=+4096 (scaled build: +256), held for one cycle, then IDLE.
- All iC=0 -> oSum=-4096 (scaled: -256). Lanes 0-7 =1 and lanes 8-15 =0 -> oSum=0.
- Lane 0 high only for first 10 RUN cycles, others 0 -> acc=10, oSum=20-4096=-4076 (scaled: -255, floor of -254.75).
- Backpressure: iReady=0 for 20 cycles after oValid -> oValid and oSum stable for all 20 cycles. Pulses of start during that time are ignored. iReady=1 together with start -> RUN next cycle, busy=1, no IDLE cycle.
- start pulsed again at RUN cycle 100 -> ignored; oValid still at original t+257 with result of the original window.
- rst_n asserted at RUN cycle 50 -> busy, oValid and oSum are 0 immediately. After release, a new start yields a correct full-window result with no carryover.
